// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with 2-flop synchronizer, tick-enabled bit timing and a valid/ready output register
module uart_rx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_clk_en,
    input  logic       i_rx,
    input  logic       i_ready,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_frame_err,
    output logic       o_overrun
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] START     = 3'd1;
    localparam logic [2:0] DATA      = 3'd2;
    localparam logic [2:0] STOP      = 3'd3;
    localparam logic [2:0] WAIT_HIGH = 3'd4;

    logic [1:0]    sync_q, sync_d;
    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    sr_q, sr_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;
    logic          ovr_q, ovr_d;
    logic          rx_s, done, bad_stop, at_last;

    assign rx_s    = sync_q[1];
    assign at_last = cnt_q == LAST;

    always_comb begin
        sync_d   = {sync_q[0], i_rx};
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        sr_d     = sr_q;
        done     = 1'b0;
        bad_stop = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_clk_en && !rx_s) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                if (i_clk_en) begin
                    cnt_d = (cnt_q == HALF) ? '0 : cnt_q + 1'b1;
                    if (cnt_q == HALF) state_d = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (i_clk_en) begin
                    cnt_d = at_last ? '0 : cnt_q + 1'b1;
                    if (at_last) begin
                        sr_d  = {rx_s, sr_q[7:1]};
                        idx_d = idx_q + 3'd1;
                        if (idx_q == 3'd7) state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (i_clk_en) begin
                    cnt_d = at_last ? '0 : cnt_q + 1'b1;
                    if (at_last) begin
                        state_d  = rx_s ? IDLE : WAIT_HIGH;
                        done     = rx_s;
                        bad_stop = !rx_s;
                    end
                end
            end
            WAIT_HIGH: state_d = (i_clk_en && rx_s) ? IDLE : WAIT_HIGH;
            default:   state_d = IDLE;
        endcase
        // a completed byte is accepted whenever the holding register is empty or being drained this cycle
        valid_d = done || (valid_q && !i_ready);
        data_d  = (done && (!valid_q || i_ready)) ? sr_q : data_q;
        ovr_d   = done && valid_q && !i_ready;
        ferr_d  = bad_stop;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_q  <= 2'b11;
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            sr_q    <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sr_q    <= sr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign o_data      = data_q;
    assign o_valid     = valid_q;
    assign o_frame_err = ferr_q;
    assign o_overrun   = ovr_q;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed scenario tasks for uart_rx at CLKS_PER_BIT=16
module tb_uart_rx;
    logic       clk = 1'b0;
    logic       i_rst, i_clk_en, i_rx, i_ready;
    logic [7:0] o_data;
    logic       o_valid, o_frame_err, o_overrun;
    int         tests = 0;
    int         fails = 0;
    int         ferr_n = 0;
    int         ovr_n = 0;

    uart_rx #(.CLKS_PER_BIT(16)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_clk_en(i_clk_en), .i_rx(i_rx), .i_ready(i_ready),
        .o_data(o_data), .o_valid(o_valid), .o_frame_err(o_frame_err), .o_overrun(o_overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        ferr_n <= ferr_n + int'(o_frame_err);
        ovr_n  <= ovr_n + int'(o_overrun);
    end

    task automatic step(input logic en);
        i_clk_en = en;
        @(negedge clk);
    endtask

    task automatic send_bit(input logic v, input int div);
        i_rx = v;
        repeat (16) begin
            step(1'b1);
            repeat (div - 1) step(1'b0);
        end
    endtask

    task automatic send_head(input logic [7:0] b, input int div);
        send_bit(1'b0, div);
        for (int i = 0; i < 8; i++) send_bit(b[i], div);
    endtask

    task automatic send_byte(input logic [7:0] b, input int div);
        send_head(b, div);
        send_bit(1'b1, div);
    endtask

    task automatic consume();
        i_ready = 1'b1;
        step(1'b1);
        i_ready = 1'b0;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        repeat (3) step(1'b1);
        tests++; if (o_data !== 8'h00) begin fails++; $display("FAIL reset_data: got %h want 00", o_data); end
        tests++; if (o_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", o_valid); end
        tests++; if (o_frame_err !== 1'b0) begin fails++; $display("FAIL reset_ferr: got %b want 0", o_frame_err); end
        tests++; if (o_overrun !== 1'b0) begin fails++; $display("FAIL reset_ovr: got %b want 0", o_overrun); end
        i_rst = 1'b0;
        repeat (4) step(1'b1);
    endtask

    task automatic test_basic();
        int f0, o0;
        f0 = ferr_n; o0 = ovr_n;
        send_head(8'hA5, 1);
        i_rx = 1'b1;
        repeat (10) step(1'b1);
        tests++; if (o_valid !== 1'b0) begin fails++; $display("FAIL basic_early_valid: got %b want 0", o_valid); end
        step(1'b1);
        tests++; if (o_valid !== 1'b1) begin fails++; $display("FAIL basic_valid: got %b want 1", o_valid); end
        tests++; if (o_data !== 8'hA5) begin fails++; $display("FAIL basic_data: got %h want a5", o_data); end
        repeat (5) step(1'b1);
        tests++; if (ferr_n - f0 !== 0) begin fails++; $display("FAIL basic_ferr: got %0d pulses want 0", ferr_n - f0); end
        tests++; if (ovr_n - o0 !== 0) begin fails++; $display("FAIL basic_ovr: got %0d pulses want 0", ovr_n - o0); end
        consume();
        tests++; if (o_valid !== 1'b0) begin fails++; $display("FAIL basic_consume: got %b want 0", o_valid); end
    endtask

    task automatic test_overrun();
        int o0;
        send_byte(8'h3C, 1);
        tests++; if (o_data !== 8'h3C) begin fails++; $display("FAIL ovr_first: got %h want 3c", o_data); end
        o0 = ovr_n;
        send_byte(8'h81, 1);
        step(1'b1);
        tests++; if (o_data !== 8'h3C) begin fails++; $display("FAIL ovr_keep: got %h want 3c", o_data); end
        tests++; if (o_valid !== 1'b1) begin fails++; $display("FAIL ovr_valid: got %b want 1", o_valid); end
        tests++; if (ovr_n - o0 !== 1) begin fails++; $display("FAIL ovr_pulses: got %0d want 1", ovr_n - o0); end
        consume();
        tests++; if (o_valid !== 1'b0) begin fails++; $display("FAIL ovr_drain: got %b want 0", o_valid); end
    endtask

    task automatic test_break();
        int f0;
        f0 = ferr_n;
        i_rx = 1'b0;
        repeat (200 * 16) step(1'b1);
        i_rx = 1'b1;
        repeat (32) step(1'b1);
        tests++; if (ferr_n - f0 !== 1) begin fails++; $display("FAIL break_ferr: got %0d pulses want 1", ferr_n - f0); end
        tests++; if (o_valid !== 1'b0) begin fails++; $display("FAIL break_valid: got %b want 0", o_valid); end
        send_byte(8'h55, 1);
        tests++; if (o_data !== 8'h55 || o_valid !== 1'b1) begin fails++; $display("FAIL break_next: got %h/%b want 55/1", o_data, o_valid); end
        consume();
    endtask

    task automatic test_glitch();
        int f0, o0;
        f0 = ferr_n; o0 = ovr_n;
        i_rx = 1'b0;
        repeat (4) step(1'b1);
        i_rx = 1'b1;
        repeat (40) step(1'b1);
        tests++; if (o_valid !== 1'b0) begin fails++; $display("FAIL glitch_valid: got %b want 0", o_valid); end
        tests++; if (ferr_n - f0 !== 0 || ovr_n - o0 !== 0) begin fails++; $display("FAIL glitch_pulses: got ferr %0d ovr %0d want 0 0", ferr_n - f0, ovr_n - o0); end
        send_byte(8'hC3, 1);
        tests++; if (o_data !== 8'hC3 || o_valid !== 1'b1) begin fails++; $display("FAIL glitch_next: got %h/%b want c3/1", o_data, o_valid); end
        consume();
    endtask

    task automatic test_clk_en();
        int o0;
        send_byte(8'hFF, 3);
        step(1'b1);
        tests++; if (o_data !== 8'hFF || o_valid !== 1'b1) begin fails++; $display("FAIL clken_data: got %h/%b want ff/1", o_data, o_valid); end
        o0 = ovr_n;
        send_head(8'h00, 1);
        i_rx = 1'b1;
        repeat (10) step(1'b1);
        i_ready = 1'b1;
        step(1'b1);
        i_ready = 1'b0;
        tests++; if (o_valid !== 1'b1) begin fails++; $display("FAIL b2b_valid: got %b want 1", o_valid); end
        tests++; if (o_data !== 8'h00) begin fails++; $display("FAIL b2b_data: got %h want 00", o_data); end
        repeat (5) step(1'b1);
        tests++; if (ovr_n - o0 !== 0) begin fails++; $display("FAIL b2b_ovr: got %0d pulses want 0", ovr_n - o0); end
    endtask

    task automatic test_reset_mid();
        int f0, o0;
        consume();
        send_byte(8'h6B, 1);
        f0 = ferr_n; o0 = ovr_n;
        send_bit(1'b0, 1);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1);
        i_rx = 1'b0;
        repeat (8) step(1'b1);
        i_rst = 1'b1;
        repeat (2) step(1'b0);
        tests++; if (o_valid !== 1'b0 || o_data !== 8'h00) begin fails++; $display("FAIL rstmid_out: got %h/%b want 00/0", o_data, o_valid); end
        i_rst = 1'b0;
        i_rx = 1'b1;
        repeat (40) step(1'b1);
        tests++; if (ferr_n - f0 !== 0 || ovr_n - o0 !== 0 || o_valid !== 1'b0) begin fails++; $display("FAIL rstmid_quiet: got ferr %0d ovr %0d valid %b want 0 0 0", ferr_n - f0, ovr_n - o0, o_valid); end
        send_byte(8'h12, 1);
        tests++; if (o_data !== 8'h12 || o_valid !== 1'b1) begin fails++; $display("FAIL rstmid_next: got %h/%b want 12/1", o_data, o_valid); end
    endtask

    initial begin
        i_rst = 1'b1; i_clk_en = 1'b1; i_rx = 1'b1; i_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_overrun();
        test_break();
        test_glitch();
        test_clk_en();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
